// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one external SRAM between the SNES, the SA-1 and an optional MCU port.
//
// Build option: define SRAM_ARB_MCU_PORT_EN to enable the MCU port and the SA-1 starvation guard.
// Without it the MCU inputs are ignored, o_mcu_ack/o_mcu_rdata are tied to 0 and
// arbitration is SNES over SA-1.
//
// Ports:
//   i_clk, i_rst_n                        clock, synchronous active-low reset
//   i_snes_req/addr/we/wdata              single-cycle SNES request, latched into a one-deep slot
//   o_snes_rdata, o_snes_rdy              SNES read data, single-cycle completion pulse
//   i_sa1_req/addr/we/wdata               SA-1 level request, held until o_sa1_ack
//   o_sa1_rdata, o_sa1_ack                SA-1 read data, single-cycle completion pulse
//   i_mcu_req/addr/we/wdata               MCU level request, held until o_mcu_ack
//   o_mcu_rdata, o_mcu_ack                MCU read data, single-cycle completion pulse
//   o_ram_addr, o_ram_dout, i_ram_din     external SRAM address and data
//   o_ram_drive, o_ram_oe_n, o_ram_we_n   data-bus output enable and SRAM strobes
//   o_busy                                high while the state machine is not idle
module sram_bus_arbiter #(
    parameter int unsigned ACC_CYCLES = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_snes_req,
    input  logic [23:0] i_snes_addr,
    input  logic        i_snes_we,
    input  logic [7:0]  i_snes_wdata,
    output logic [7:0]  o_snes_rdata,
    output logic        o_snes_rdy,
    input  logic        i_sa1_req,
    input  logic [23:0] i_sa1_addr,
    input  logic        i_sa1_we,
    input  logic [7:0]  i_sa1_wdata,
    output logic [7:0]  o_sa1_rdata,
    output logic        o_sa1_ack,
    input  logic        i_mcu_req,
    input  logic [23:0] i_mcu_addr,
    input  logic        i_mcu_we,
    input  logic [7:0]  i_mcu_wdata,
    output logic [7:0]  o_mcu_rdata,
    output logic        o_mcu_ack,
    output logic [23:0] o_ram_addr,
    output logic [7:0]  o_ram_dout,
    input  logic [7:0]  i_ram_din,
    output logic        o_ram_drive,
    output logic        o_ram_oe_n,
    output logic        o_ram_we_n,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    localparam logic [1:0] G_SNES = 2'd0;
    localparam logic [1:0] G_SA1  = 2'd1;
    localparam logic [1:0] G_MCU  = 2'd2;
    state_t      r_state;
    logic [1:0]  r_gnt;
    logic        r_we;
    logic [3:0]  r_cnt;
    logic [2:0]  r_sa1_cnt;
    logic        r_pend;
    logic [23:0] r_pend_addr;
    logic        r_pend_we;
    logic [7:0]  r_pend_wdata;
    logic        r_overrun;
    logic [7:0]  r_snes_rdata;
    logic [7:0]  r_sa1_rdata;
    logic [7:0]  r_mcu_rdata;
    logic        r_snes_rdy;
    logic        r_sa1_ack;
    logic        r_mcu_ack;
    logic [23:0] r_ram_addr;
    logic [7:0]  r_ram_dout;
    logic        r_ram_drive;
    logic        r_ram_oe_n;
    logic        r_ram_we_n;
    logic        w_mcu_req;
    logic        w_snes;
    logic [23:0] w_snes_addr;
    logic        w_snes_we;
    logic [7:0]  w_snes_wdata;
    logic        w_mcu_win;
    logic        w_any;
    logic [1:0]  w_gnt;
    logic [23:0] w_addr;
    logic        w_we;
    logic [7:0]  w_wdata;
    logic        w_unused;

`ifdef SRAM_ARB_MCU_PORT_EN
    assign w_mcu_req   = i_mcu_req;
    assign o_mcu_ack   = r_mcu_ack;
    assign o_mcu_rdata = r_mcu_rdata;
    // r_overrun is a simulation-visible debug flag with no consumer in hardware
    assign w_unused    = r_overrun;
`else
    assign w_mcu_req   = 1'b0;
    assign o_mcu_ack   = 1'b0;
    assign o_mcu_rdata = 8'h00;
    assign w_unused    = ^{r_overrun, i_mcu_req, r_mcu_ack, r_mcu_rdata};
`endif

    // A pulse arriving in the grant cycle takes part directly, overriding the slot contents
    assign w_snes       = r_pend | i_snes_req;
    assign w_snes_addr  = i_snes_req ? i_snes_addr  : r_pend_addr;
    assign w_snes_we    = i_snes_req ? i_snes_we    : r_pend_we;
    assign w_snes_wdata = i_snes_req ? i_snes_wdata : r_pend_wdata;
    // MCU wins over a waiting SA-1 only once the SA-1 has taken four grants in a row
    assign w_mcu_win    = w_mcu_req & (~i_sa1_req | (r_sa1_cnt == 3'd4));
    assign w_any        = w_snes | i_sa1_req | w_mcu_req;
    assign w_gnt        = w_snes ? G_SNES : (w_mcu_win ? G_MCU : G_SA1);
    assign w_addr       = w_snes ? w_snes_addr  : (w_mcu_win ? i_mcu_addr  : i_sa1_addr);
    assign w_we         = w_snes ? w_snes_we    : (w_mcu_win ? i_mcu_we    : i_sa1_we);
    assign w_wdata      = w_snes ? w_snes_wdata : (w_mcu_win ? i_mcu_wdata : i_sa1_wdata);

    assign o_snes_rdata = r_snes_rdata;
    assign o_snes_rdy   = r_snes_rdy;
    assign o_sa1_rdata  = r_sa1_rdata;
    assign o_sa1_ack    = r_sa1_ack;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_dout   = r_ram_dout;
    assign o_ram_drive  = r_ram_drive;
    assign o_ram_oe_n   = r_ram_oe_n;
    assign o_ram_we_n   = r_ram_we_n;
    assign o_busy       = r_state != IDLE;

    // A new pulse always wins over the clear, so a request landing in DONE is kept
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pend       <= 1'b0;
            r_pend_addr  <= 24'h0;
            r_pend_we    <= 1'b0;
            r_pend_wdata <= 8'h0;
            r_overrun    <= 1'b0;
        end else if (i_snes_req) begin
            r_pend       <= 1'b1;
            r_pend_addr  <= i_snes_addr;
            r_pend_we    <= i_snes_we;
            r_pend_wdata <= i_snes_wdata;
            r_overrun    <= r_overrun | r_pend;
        end else if (r_state == DONE && r_gnt == G_SNES) begin
            r_pend       <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_gnt        <= G_SNES;
            r_we         <= 1'b0;
            r_cnt        <= 4'd0;
            r_sa1_cnt    <= 3'd0;
            r_snes_rdata <= 8'h0;
            r_sa1_rdata  <= 8'h0;
            r_mcu_rdata  <= 8'h0;
            r_snes_rdy   <= 1'b0;
            r_sa1_ack    <= 1'b0;
            r_mcu_ack    <= 1'b0;
            r_ram_addr   <= 24'h0;
            r_ram_dout   <= 8'h0;
            r_ram_drive  <= 1'b0;
            r_ram_oe_n   <= 1'b1;
            r_ram_we_n   <= 1'b1;
        end else begin
            r_snes_rdy <= 1'b0;
            r_sa1_ack  <= 1'b0;
            r_mcu_ack  <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_state     <= SETUP;
                    r_gnt       <= w_gnt;
                    r_we        <= w_we;
                    r_ram_addr  <= w_addr;
                    r_ram_dout  <= w_wdata;
                    r_ram_drive <= w_we;
                    r_ram_oe_n  <= w_we;
                    // only SA-1 grants taken while the MCU waits count toward the guard
                    r_sa1_cnt   <= (w_gnt == G_SA1 && w_mcu_req) ? r_sa1_cnt + 3'd1 : 3'd0;
                end
                SETUP: begin
                    r_state    <= ACCESS;
                    r_cnt      <= 4'(ACC_CYCLES);
                    r_ram_we_n <= !(r_we && ACC_CYCLES > 1);
                end
                ACCESS: if (r_cnt == 4'd1) begin
                    r_state      <= DONE;
                    r_snes_rdy   <= r_gnt == G_SNES;
                    r_sa1_ack    <= r_gnt == G_SA1;
                    r_mcu_ack    <= r_gnt == G_MCU;
                    r_snes_rdata <= (!r_we && r_gnt == G_SNES) ? i_ram_din : r_snes_rdata;
                    r_sa1_rdata  <= (!r_we && r_gnt == G_SA1)  ? i_ram_din : r_sa1_rdata;
                    r_mcu_rdata  <= (!r_we && r_gnt == G_MCU)  ? i_ram_din : r_mcu_rdata;
                    r_ram_drive  <= 1'b0;
                    r_ram_oe_n   <= 1'b1;
                    r_ram_we_n   <= 1'b1;
                end else begin
                    r_cnt      <= r_cnt - 4'd1;
                    // write strobe releases one cycle before the end so data holds past WE_N rising
                    r_ram_we_n <= !(r_we && r_cnt != 4'd2);
                end
                DONE: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed bench with a transaction-timeline model of the SRAM arbiter.
module tb_sram_bus_arbiter;
    localparam int ACC  = 3;
    localparam int LAST = ACC + 2;
`ifdef SRAM_ARB_MCU_PORT_EN
    localparam bit MCU_EN = 1'b1;
`else
    localparam bit MCU_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snes_req = 1'b0;
    logic [23:0] snes_addr = 24'h0;
    logic        snes_we = 1'b0;
    logic [7:0]  snes_wdata = 8'h0;
    logic [7:0]  snes_rdata;
    logic        snes_rdy;
    logic        sa1_req = 1'b0;
    logic [23:0] sa1_addr = 24'h0;
    logic        sa1_we = 1'b0;
    logic [7:0]  sa1_wdata = 8'h0;
    logic [7:0]  sa1_rdata;
    logic        sa1_ack;
    logic        mcu_req = 1'b0;
    logic [23:0] mcu_addr = 24'h0;
    logic        mcu_we = 1'b0;
    logic [7:0]  mcu_wdata = 8'h0;
    logic [7:0]  mcu_rdata;
    logic        mcu_ack;
    logic [23:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h0;
    logic        ram_drive;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        busy;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ACC_CYCLES(ACC)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_snes_req(snes_req), .i_snes_addr(snes_addr), .i_snes_we(snes_we), .i_snes_wdata(snes_wdata),
        .o_snes_rdata(snes_rdata), .o_snes_rdy(snes_rdy),
        .i_sa1_req(sa1_req), .i_sa1_addr(sa1_addr), .i_sa1_we(sa1_we), .i_sa1_wdata(sa1_wdata),
        .o_sa1_rdata(sa1_rdata), .o_sa1_ack(sa1_ack),
        .i_mcu_req(mcu_req), .i_mcu_addr(mcu_addr), .i_mcu_we(mcu_we), .i_mcu_wdata(mcu_wdata),
        .o_mcu_rdata(mcu_rdata), .o_mcu_ack(mcu_ack),
        .o_ram_addr(ram_addr), .o_ram_dout(ram_dout), .i_ram_din(ram_din),
        .o_ram_drive(ram_drive), .o_ram_oe_n(ram_oe_n), .o_ram_we_n(ram_we_n), .o_busy(busy)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int we_low = 0;
    int drive_hi = 0;
    int snes_acks = 0;
    int sa1_acks = 0;
    int mcu_acks = 0;

    // model: t counts cycles since grant (0 = idle), g is the granted port 0 SNES / 1 SA-1 / 2 MCU
    int          t = 0;
    int          g = 0;
    int          streak = 0;
    bit          m_valid = 1'b0;
    bit          m_we = 1'b0;
    logic [23:0] m_addr = 24'h0;
    logic [7:0]  m_dout = 8'h0;
    logic [7:0]  m_rd [3];
    bit          pend = 1'b0;
    logic [23:0] p_addr = 24'h0;
    bit          p_we = 1'b0;
    logic [7:0]  p_wd = 8'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        bit clr;
        clr = 1'b0;
        cyc++;
        if (!rst_n) begin
            t = 0;
            pend = 1'b0;
            streak = 0;
            m_addr = 24'h0;
            m_we = 1'b0;
            for (int i = 0; i < 3; i++) m_rd[i] = 8'h0;
            m_valid = 1'b1;
        end else begin
            if (t == 0) begin
                if (pend || snes_req) begin
                    g = 0;
                    m_addr = snes_req ? snes_addr : p_addr;
                    m_we = snes_req ? snes_we : p_we;
                    m_dout = snes_req ? snes_wdata : p_wd;
                    streak = 0;
                    t = 1;
                end else if (MCU_EN && mcu_req && (!sa1_req || streak >= 4)) begin
                    g = 2;
                    m_addr = mcu_addr;
                    m_we = mcu_we;
                    m_dout = mcu_wdata;
                    streak = 0;
                    t = 1;
                end else if (sa1_req) begin
                    g = 1;
                    m_addr = sa1_addr;
                    m_we = sa1_we;
                    m_dout = sa1_wdata;
                    streak = (MCU_EN && mcu_req) ? streak + 1 : 0;
                    t = 1;
                end
            end else if (t == LAST) begin
                clr = (g == 0);
                t = 0;
            end else begin
                t++;
                if (t == LAST && !m_we) m_rd[g] = ram_din;
            end
            if (snes_req) begin
                pend = 1'b1;
                p_addr = snes_addr;
                p_we = snes_we;
                p_wd = snes_wdata;
            end else if (clr) begin
                pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!ram_we_n) we_low++;
        if (ram_drive) drive_hi++;
        if (snes_rdy) snes_acks++;
        if (sa1_ack) sa1_acks++;
        if (mcu_ack) mcu_acks++;
    end

    always @(negedge clk) begin
        bit win;
        win = t >= 1 && t <= ACC + 1;
        if (m_valid) begin
            chk("busy", busy, t != 0);
            chk("ram_drive", ram_drive, m_we && win);
            chk("ram_oe_n", ram_oe_n, !(!m_we && win));
            chk("ram_we_n", ram_we_n, !(m_we && t >= 2 && t <= ACC));
            chk("snes_rdy", snes_rdy, t == LAST && g == 0);
            chk("sa1_ack", sa1_ack, t == LAST && g == 1);
            chk("mcu_ack", mcu_ack, t == LAST && g == 2);
            chk("ram_addr", ram_addr, m_addr);
            if (m_we && win) chk("ram_dout", ram_dout, m_dout);
            chk("snes_rdata", snes_rdata, m_rd[0]);
            chk("sa1_rdata", sa1_rdata, m_rd[1]);
            chk("mcu_rdata", mcu_rdata, m_rd[2]);
        end
    end

    // mask bits: 0 SNES, 1 SA-1, 2 MCU
    task automatic wait_ack(input logic [2:0] mask, output int at, output int who);
        bit found;
        found = 1'b0;
        at = -1;
        who = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (|(mask & {mcu_ack, sa1_ack, snes_rdy})) begin
                found = 1'b1;
                at = cyc;
                who = snes_rdy ? 0 : (sa1_ack ? 1 : 2);
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: no ack for mask %b within 40 cycles", mask);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int at0, at1, who, w0, d0, a0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_we_n", ram_we_n, 1);
        chk("rst_oe_n", ram_oe_n, 1);
        chk("rst_drive", ram_drive, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_acks", {snes_rdy, sa1_ack, mcu_ack}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        // SNES read
        snes_addr = 24'h008000;
        snes_we = 1'b0;
        ram_din = 8'hA5;
        snes_req = 1'b1;
        at0 = cyc;
        w0 = we_low;
        @(negedge clk);
        snes_req = 1'b0;
        wait_ack(3'b001, at1, who);
        chk("s1_latency", at1 - at0, 5);
        chk("s1_rdata", snes_rdata, 8'hA5);
        @(negedge clk);
        chk("s1_we_n_never_low", we_low - w0, 0);
        // SA-1 write, inputs changed mid-access
        w0 = we_low;
        d0 = drive_hi;
        a0 = sa1_acks;
        sa1_addr = 24'hE00010;
        sa1_we = 1'b1;
        sa1_wdata = 8'h3C;
        sa1_req = 1'b1;
        repeat (3) @(negedge clk);
        sa1_addr = 24'hFFFFFF;
        sa1_wdata = 8'h00;
        wait_ack(3'b010, at1, who);
        sa1_req = 1'b0;
        chk("s2_addr_captured", ram_addr, 24'hE00010);
        repeat (3) @(negedge clk);
        chk("s2_we_low_cycles", we_low - w0, 2);
        chk("s2_drive_cycles", drive_hi - d0, 4);
        chk("s2_ack_count", sa1_acks - a0, 1);
        // SNES and SA-1 in the same cycle
        ram_din = 8'h11;
        snes_addr = 24'h123456;
        snes_we = 1'b0;
        snes_req = 1'b1;
        sa1_addr = 24'h400000;
        sa1_we = 1'b0;
        sa1_req = 1'b1;
        @(negedge clk);
        snes_req = 1'b0;
        wait_ack(3'b011, at0, who);
        chk("s3_first_is_snes", who, 0);
        ram_din = 8'h77;
        wait_ack(3'b010, at1, who);
        sa1_req = 1'b0;
        chk("s3_gap", at1 - at0, 6);
        chk("s3_snes_rdata", snes_rdata, 8'h11);
        chk("s3_sa1_rdata", sa1_rdata, 8'h77);
        // SNES pulse during an SA-1 access waits in the slot
        @(negedge clk);
        ram_din = 8'h42;
        sa1_addr = 24'h300000;
        sa1_req = 1'b1;
        repeat (2) @(negedge clk);
        snes_addr = 24'h00ABCD;
        snes_we = 1'b1;
        snes_wdata = 8'h99;
        snes_req = 1'b1;
        @(negedge clk);
        snes_req = 1'b0;
        wait_ack(3'b011, at0, who);
        sa1_req = 1'b0;
        chk("s4_first_is_sa1", who, 1);
        wait_ack(3'b001, at1, who);
        chk("s4_gap", at1 - at0, 6);
        chk("s4_snes_rdata_held", snes_rdata, 8'h11);
        chk("s4_sa1_rdata", sa1_rdata, 8'h42);
        // SA-1 and MCU held continuously
        repeat (2) @(negedge clk);
        a0 = mcu_acks;
        sa1_addr = 24'h600000;
        sa1_we = 1'b0;
        mcu_addr = 24'h500000;
        mcu_we = 1'b0;
        sa1_req = 1'b1;
        mcu_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_ack(3'b110, at0, who);
            chk("s5_grant_seq", who, (MCU_EN && i % 5 == 4) ? 2 : 1);
        end
        sa1_req = 1'b0;
        mcu_req = 1'b0;
        @(negedge clk);
        chk("s5_mcu_ack_count", mcu_acks - a0, MCU_EN ? 2 : 0);
        // reset in the middle of a write access
        repeat (2) @(negedge clk);
        a0 = MCU_EN ? mcu_acks : sa1_acks;
        if (MCU_EN) begin
            mcu_addr = 24'h001234;
            mcu_we = 1'b1;
            mcu_wdata = 8'h55;
            mcu_req = 1'b1;
        end else begin
            sa1_addr = 24'h001234;
            sa1_we = 1'b1;
            sa1_wdata = 8'h55;
            sa1_req = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("s6_we_n_active", ram_we_n, 0);
        rst_n = 1'b0;
        mcu_req = 1'b0;
        sa1_req = 1'b0;
        @(negedge clk);
        chk("s6_we_n_after_rst", ram_we_n, 1);
        chk("s6_busy_after_rst", busy, 0);
        chk("s6_drive_after_rst", ram_drive, 0);
        chk("s6_oe_n_after_rst", ram_oe_n, 1);
        repeat (6) @(negedge clk);
        chk("s6_no_ack", (MCU_EN ? mcu_acks : sa1_acks) - a0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_bus_arbiter.md
SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ACC_CYCLES, default 3, setting the SRAM strobe length in CLK cycles (legal range 1-15).
REQ-002 The block SHALL have the following ports, one per line as name, direction, width and meaning:
- CLK  in  1  system clock.
- RST_N  in  1  reset; synchronous, active-low.
- SNES_REQ  in  1  single-cycle pulse; a decoded SNES cycle with ROM_HIT set.
- SNES_ADDR  in  24  translated ROM/SRAM address from the address decoder.
- SNES_WE  in  1  SNES request is a write (IS_WRITABLE already applied).
- SNES_WDATA  in  8  SNES write data.
- SNES_RDATA  out  8  SNES read data.
- SNES_RDY  out  1  single-cycle completion pulse for the SNES request.
- SA1_REQ, SA1_ADDR[23:0], SA1_WE, SA1_WDATA[7:0]  in  SA-1 request port; level request, held until acknowledged.
- SA1_RDATA[7:0], SA1_ACK  out  SA-1 read data and completion pulse.
- MCU_REQ, MCU_ADDR[23:0], MCU_WE, MCU_WDATA[7:0]  in  MCU request port; same rules as the SA-1 port.
- MCU_RDATA[7:0], MCU_ACK  out  MCU read data and completion pulse.
- RAM_ADDR  out  24  external SRAM address.
- RAM_DOUT  out  8  external SRAM write data.
- RAM_DIN  in  8  external SRAM read data.
- RAM_DRIVE  out  1  data-bus output enable.
- RAM_OE_N  out  1  SRAM output enable, active-low.
- RAM_WE_N  out  1  SRAM write enable, active-low.
- BUSY  out  1  high while the state machine is not in IDLE.

Function
REQ-003 The block SHALL implement the states IDLE, SETUP, ACCESS and DONE.
REQ-004 A SNES_REQ pulse SHALL be latched into a one-deep pending slot together with its address, write flag and data, whatever the current state.
REQ-005 In IDLE, the block SHALL grant with fixed priority SNES pending, then SA1_REQ, then MCU_REQ, and move to SETUP on the next cycle.
REQ-006 A SNES_REQ arriving in the same cycle as a grant decision SHALL take part in that decision, so that the SNES wins.
REQ-007 In SETUP (1 cycle), the block SHALL drive RAM_ADDR and RAM_DOUT from the granted port, set RAM_DRIVE equal to the write flag, and drive RAM_OE_N equal to the write flag.
REQ-008 In ACCESS (ACC_CYCLES cycles, counted by a 4-bit counter), reads SHALL hold RAM_OE_N low, and writes SHALL hold RAM_WE_N low except on the final ACCESS cycle.
REQ-009 For reads, RAM_DIN SHALL be registered at the end of the last ACCESS cycle into the granted port's RDATA register.
REQ-010 Each RDATA register SHALL hold its value until that port's next read completes.
REQ-011 In DONE (1 cycle), the block SHALL assert exactly one of SNES_RDY, SA1_ACK or MCU_ACK, deassert RAM_DRIVE, RAM_OE_N and RAM_WE_N, clear the SNES pending slot if the SNES was granted, and return to IDLE.
REQ-012 Latency from a request sampled in IDLE to its ack SHALL be ACC_CYCLES+2 cycles, with no back-to-back gap other than the one IDLE cycle.
REQ-013 Address, write flag and data SHALL be captured at grant; changes on the port inputs during an access SHALL be ignored.
REQ-014 A second SNES_REQ while the slot is pending SHALL overwrite the slot, and a sticky bit (internal, visible in simulation) SHALL record the overrun.
REQ-015 Starvation guard: after 4 consecutive SA-1 grants while MCU_REQ is high, the next grant SHALL go to the MCU unless a SNES request is pending.
REQ-016 The consecutive-grant counter SHALL clear on any MCU grant or SNES grant.

Reset
REQ-017 With RST_N low at a CLK edge, the block SHALL enter IDLE, clear the pending slot, overrun bit, counters and RDATA registers, set RAM_OE_N and RAM_WE_N to 1, set RAM_DRIVE, BUSY and all acks to 0, and set RAM_ADDR to 0.
REQ-018 If reset occurs mid-access, the access SHALL be abandoned without an ack, and the SRAM strobes SHALL be inactive on the first cycle after the reset edge.

Configuration
REQ-019 With macro SRAM_ARB_MCU_PORT_EN defined, the MCU port and the starvation guard SHALL be present as specified.
REQ-020 Without SRAM_ARB_MCU_PORT_EN, the MCU inputs SHALL be ignored, MCU_ACK and MCU_RDATA SHALL be tied to 0, and arbitration SHALL be SNES over SA-1 only.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Reset, then a SNES read at 0x00_8000 with RAM_DIN=0xA5 and ACC_CYCLES=3 -> SNES_RDY 5 cycles later, SNES_RDATA=0xA5, WE_N stays high.
- SA-1 write 0xE0_0010 with data 0x3C -> RAM_WE_N low for exactly 2 cycles, RAM_DRIVE high for 4 cycles, one SA1_ACK.
- SNES_REQ in the same cycle as SA1_REQ in IDLE -> SNES granted first, SA1_ACK exactly 6 cycles after SNES_RDY.
- SA1_REQ and MCU_REQ held continuously -> grant sequence SA1×4, MCU, SA1×4, MCU …
- RST_N low during ACCESS of an MCU write -> no MCU_ACK, WE_N=1 on the next cycle, BUSY=0.
- Build without SRAM_ARB_MCU_PORT_EN while MCU_REQ is held -> MCU_ACK never asserts, SA-1 accesses are unaffected.
